// File: rtl/nes_joypad_pkg.sv
// -----------------------------------------------------------------------------
// nes_joypad_pkg
// Shared definitions for the NES joypad controller:
//   - HID usage codes mapped to NES buttons for player 1, player 2 and turbo
//   - button bit positions BTN_A..BTN_RIGHT
//   - scan FSM state encoding
//   - decode_key(): one HID usage code -> button masks for both players
// -----------------------------------------------------------------------------
package nes_joypad_pkg;

    // Button bit positions inside an 8-bit NES button mask
    localparam int unsigned BTN_A      = 0;
    localparam int unsigned BTN_B      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;

    // Player 1 key map (letters / Tab / Enter)
    localparam logic [7:0] P1_KEY_A      = 8'h0E;
    localparam logic [7:0] P1_KEY_B      = 8'h0D;
    localparam logic [7:0] P1_KEY_SELECT = 8'h2B;
    localparam logic [7:0] P1_KEY_START  = 8'h28;
    localparam logic [7:0] P1_KEY_UP     = 8'h1A;
    localparam logic [7:0] P1_KEY_DOWN   = 8'h16;
    localparam logic [7:0] P1_KEY_LEFT   = 8'h04;
    localparam logic [7:0] P1_KEY_RIGHT  = 8'h07;

    // Player 2 key map (keypad / arrow keys)
    localparam logic [7:0] P2_KEY_A      = 8'h5A;
    localparam logic [7:0] P2_KEY_B      = 8'h59;
    localparam logic [7:0] P2_KEY_SELECT = 8'h57;
    localparam logic [7:0] P2_KEY_START  = 8'h58;
    localparam logic [7:0] P2_KEY_UP     = 8'h52;
    localparam logic [7:0] P2_KEY_DOWN   = 8'h51;
    localparam logic [7:0] P2_KEY_LEFT   = 8'h50;
    localparam logic [7:0] P2_KEY_RIGHT  = 8'h4F;

    // Turbo keys (only decoded when turbo is enabled)
    localparam logic [7:0] P1_KEY_TURBO_A = 8'h0C;
    localparam logic [7:0] P1_KEY_TURBO_B = 8'h18;
    localparam logic [7:0] P2_KEY_TURBO_A = 8'h5D;
    localparam logic [7:0] P2_KEY_TURBO_B = 8'h5C;

    typedef enum logic [1:0] {
        ST_SAMPLE = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } scan_state_e;

    typedef struct packed {
        logic [7:0] p1;
        logic [7:0] p2;
    } btn_pair_t;

    // Decode one usage code. Unmapped codes (including 0x00) give empty masks.
    // Turbo keys contribute the current turbo phase to A/B, gated by turbo_en.
    function automatic btn_pair_t decode_key(input logic [7:0] code,
                                             input logic       turbo_en,
                                             input logic       turbo_phase);
        btn_pair_t m;
        m = '0;
        case (code)
            P1_KEY_A:       m.p1[BTN_A]      = 1'b1;
            P1_KEY_B:       m.p1[BTN_B]      = 1'b1;
            P1_KEY_SELECT:  m.p1[BTN_SELECT] = 1'b1;
            P1_KEY_START:   m.p1[BTN_START]  = 1'b1;
            P1_KEY_UP:      m.p1[BTN_UP]     = 1'b1;
            P1_KEY_DOWN:    m.p1[BTN_DOWN]   = 1'b1;
            P1_KEY_LEFT:    m.p1[BTN_LEFT]   = 1'b1;
            P1_KEY_RIGHT:   m.p1[BTN_RIGHT]  = 1'b1;
            P2_KEY_A:       m.p2[BTN_A]      = 1'b1;
            P2_KEY_B:       m.p2[BTN_B]      = 1'b1;
            P2_KEY_SELECT:  m.p2[BTN_SELECT] = 1'b1;
            P2_KEY_START:   m.p2[BTN_START]  = 1'b1;
            P2_KEY_UP:      m.p2[BTN_UP]     = 1'b1;
            P2_KEY_DOWN:    m.p2[BTN_DOWN]   = 1'b1;
            P2_KEY_LEFT:    m.p2[BTN_LEFT]   = 1'b1;
            P2_KEY_RIGHT:   m.p2[BTN_RIGHT]  = 1'b1;
            P1_KEY_TURBO_A: m.p1[BTN_A]      = turbo_en & turbo_phase;
            P1_KEY_TURBO_B: m.p1[BTN_B]      = turbo_en & turbo_phase;
            P2_KEY_TURBO_A: m.p2[BTN_A]      = turbo_en & turbo_phase;
            P2_KEY_TURBO_B: m.p2[BTN_B]      = turbo_en & turbo_phase;
            default:        m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/nes_joypad_shreg.sv
// -----------------------------------------------------------------------------
// nes_joypad_shreg
// One NES controller's 8-bit parallel-in/serial-out register ($4016/$4017 side).
//   strobe=1        : reload from committed buttons every cycle
//   strobe=0 and rd : shift right, bit 7 filled with 1 (reads 9+ return 1)
//   otherwise       : hold
// Ports:
//   clk, reset_n (async active-low)
//   strobe   in  1  current (pre-write) strobe latch
//   rd       in  1  one-cycle read pulse for this player
//   buttons  in  8  committed button mask
//   data     out 1  serial bit (register bit 0), valid in the read cycle
// -----------------------------------------------------------------------------
module nes_joypad_shreg
    import nes_joypad_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       strobe,
    input  logic       rd,
    input  logic [7:0] buttons,
    output logic       data
);

    logic [7:0] shreg_r;
    logic [7:0] shreg_s;

    // Next-value selection: reload has priority over shift
    always_comb begin
        shreg_s = shreg_r;
        if (strobe) begin
            shreg_s = buttons;
        end else if (rd) begin
            shreg_s = {1'b1, shreg_r[7:1]};
        end else begin
            shreg_s = shreg_r;
        end
    end

    // Shift register state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg_r <= 8'h00;
        end else begin
            shreg_r <= shreg_s;
        end
    end

    assign data = shreg_r[BTN_A];

endmodule

// File: rtl/nes_joypad_ctrl.sv
// -----------------------------------------------------------------------------
// nes_joypad_ctrl
// Turns the 32-bit keycode PIO word (four HID usage codes) into two NES
// controller button masks and serves them through the $4016/$4017
// strobe/serial-read protocol.
// Scan loop (6 cycles): SAMPLE -> SCAN x4 (one byte each) -> COMMIT.
// Optional build macro NES_JOYPAD_TURBO_EN adds a free-running TURBO_W-bit
// counter whose MSB is OR'd into A/B while a turbo key is held.
// Ports:
//   clk, reset_n         clock, async active-low reset
//   keycode     in  32   packed usage codes, byte 0 = bits 7:0, 0x00 = none
//   reg_we      in  1    CPU write to $4016
//   reg_wdata0  in  1    strobe value written
//   rd_p1/rd_p2 in  1    CPU read pulses of $4016 / $4017
//   p1_data/p2_data out 1  serial button bits
//   p1_buttons/p2_buttons out 8  committed masks
// -----------------------------------------------------------------------------
module nes_joypad_ctrl
    import nes_joypad_pkg::*;
#(
    parameter int unsigned TURBO_W = 20
)(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] keycode,
    input  logic        reg_we,
    input  logic        reg_wdata0,
    input  logic        rd_p1,
    input  logic        rd_p2,
    output logic        p1_data,
    output logic        p2_data,
    output logic [7:0]  p1_buttons,
    output logic [7:0]  p2_buttons
);

    scan_state_e state_r, state_s;
    logic [1:0]  idx_r, idx_s;
    logic [31:0] kc_r, kc_s;
    logic [7:0]  acc1_r, acc1_s, acc2_r, acc2_s;
    logic [7:0]  btn1_r, btn1_s, btn2_r, btn2_s;
    logic        strobe_r;
    logic [7:0]  cur_byte_s;
    btn_pair_t   dec_s;
    logic        turbo_en_s;
    logic        turbo_phase_s;

`ifdef NES_JOYPAD_TURBO_EN
    logic [TURBO_W-1:0] turbo_cnt_r;

    // Free-running turbo phase counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            turbo_cnt_r <= '0;
        end else begin
            turbo_cnt_r <= turbo_cnt_r + {{(TURBO_W-1){1'b0}}, 1'b1};
        end
    end

    assign turbo_en_s    = 1'b1;
    assign turbo_phase_s = turbo_cnt_r[TURBO_W-1];
`else
    // No counter in this build: turbo codes decode to nothing
    assign turbo_en_s    = 1'b0;
    assign turbo_phase_s = (TURBO_W > 0) ? 1'b0 : 1'b0;
`endif

    // Select the byte of the sampled word being scanned this cycle
    always_comb begin
        cur_byte_s = 8'h00;
        case (idx_r)
            2'd0:    cur_byte_s = kc_r[7:0];
            2'd1:    cur_byte_s = kc_r[15:8];
            2'd2:    cur_byte_s = kc_r[23:16];
            2'd3:    cur_byte_s = kc_r[31:24];
            default: cur_byte_s = 8'h00;
        endcase
    end

    assign dec_s = decode_key(cur_byte_s, turbo_en_s, turbo_phase_s);

    // Scan FSM next-state and datapath
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        kc_s    = kc_r;
        acc1_s  = acc1_r;
        acc2_s  = acc2_r;
        btn1_s  = btn1_r;
        btn2_s  = btn2_r;
        case (state_r)
            ST_SAMPLE: begin
                kc_s    = keycode;
                acc1_s  = 8'h00;
                acc2_s  = 8'h00;
                idx_s   = 2'd0;
                state_s = ST_SCAN;
            end
            ST_SCAN: begin
                // OR-accumulate so duplicate codes are harmless
                acc1_s = acc1_r | dec_s.p1;
                acc2_s = acc2_r | dec_s.p2;
                idx_s  = idx_r + 2'd1;
                if (idx_r == 2'd3) begin
                    state_s = ST_COMMIT;
                end else begin
                    state_s = ST_SCAN;
                end
            end
            ST_COMMIT: begin
                btn1_s  = acc1_r;
                btn2_s  = acc2_r;
                state_s = ST_SAMPLE;
            end
            default: begin
                state_s = ST_SAMPLE;
                idx_s   = 2'd0;
            end
        endcase
    end

    // Scan FSM and button mask registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_SAMPLE;
            idx_r   <= 2'd0;
            kc_r    <= 32'h0000_0000;
            acc1_r  <= 8'h00;
            acc2_r  <= 8'h00;
            btn1_r  <= 8'h00;
            btn2_r  <= 8'h00;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            kc_r    <= kc_s;
            acc1_r  <= acc1_s;
            acc2_r  <= acc2_s;
            btn1_r  <= btn1_s;
            btn2_r  <= btn2_s;
        end
    end

    // Strobe latch; shift registers see the old value in the write cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            strobe_r <= 1'b0;
        end else if (reg_we) begin
            strobe_r <= reg_wdata0;
        end else begin
            strobe_r <= strobe_r;
        end
    end

    // Reload uses btn*_r, i.e. the mask before a same-cycle COMMIT
    nes_joypad_shreg u_shreg_p1 (
        .clk     (clk),
        .reset_n (reset_n),
        .strobe  (strobe_r),
        .rd      (rd_p1),
        .buttons (btn1_r),
        .data    (p1_data)
    );

    nes_joypad_shreg u_shreg_p2 (
        .clk     (clk),
        .reset_n (reset_n),
        .strobe  (strobe_r),
        .rd      (rd_p2),
        .buttons (btn2_r),
        .data    (p2_data)
    );

    assign p1_buttons = btn1_r;
    assign p2_buttons = btn2_r;

endmodule

// File: tb/tb_nes_joypad_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nes_joypad_ctrl
// Directed bench for nes_joypad_ctrl. Inputs change and outputs are observed
// on the falling clock edge; the design updates on the rising edge.
// -----------------------------------------------------------------------------
module tb_nes_joypad_ctrl;

    logic        clk;
    logic        reset_n;
    logic [31:0] keycode;
    logic        reg_we;
    logic        reg_wdata0;
    logic        rd_p1;
    logic        rd_p2;
    logic        p1_data;
    logic        p2_data;
    logic [7:0]  p1_buttons;
    logic [7:0]  p2_buttons;

    int n_tests;
    int n_fail;

    nes_joypad_ctrl #(.TURBO_W(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .keycode    (keycode),
        .reg_we     (reg_we),
        .reg_wdata0 (reg_wdata0),
        .rd_p1      (rd_p1),
        .rd_p2      (rd_p2),
        .p1_data    (p1_data),
        .p2_data    (p2_data),
        .p1_buttons (p1_buttons),
        .p2_buttons (p2_buttons)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe_write(input logic v);
        @(negedge clk);
        reg_we     = 1'b1;
        reg_wdata0 = v;
        @(negedge clk);
        reg_we     = 1'b0;
        reg_wdata0 = 1'b0;
    endtask

    task automatic latch();
        strobe_write(1'b1);
        strobe_write(1'b0);
    endtask

    task automatic read_p1(input string tag, input logic exp);
        @(negedge clk);
        rd_p1 = 1'b1;
        check_eq(tag, {7'd0, p1_data}, {7'd0, exp});
        @(negedge clk);
        rd_p1 = 1'b0;
    endtask

    // Bounded wait for both masks to match, then one comparison each
    task automatic wait_buttons(input string tag, input logic [7:0] e1, input logic [7:0] e2);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (p1_buttons == e1 && p2_buttons == e2) break;
        end
        check_eq({tag, "_p1"}, p1_buttons, e1);
        check_eq({tag, "_p2"}, p2_buttons, e2);
    endtask

    initial begin
        logic [8:0] seq9;
        logic [5:0] seq6;
        logic       seen0, seen1;
        n_tests    = 0;
        n_fail     = 0;
        reset_n    = 1'b0;
        keycode    = 32'h0000_0E28;
        reg_we     = 1'b0;
        reg_wdata0 = 1'b0;
        rd_p1      = 1'b0;
        rd_p2      = 1'b0;

        // 1. Reset state, then K+Enter commits to A|Start
        tick(5);
        check_eq("rst_p1_buttons", p1_buttons, 8'h00);
        check_eq("rst_p2_buttons", p2_buttons, 8'h00);
        check_eq("rst_p1_data", {7'd0, p1_data}, 8'h00);
        check_eq("rst_p2_data", {7'd0, p2_data}, 8'h00);
        reset_n = 1'b1;
        wait_buttons("t1", 8'h09, 8'h00);

        // 2. Latch and serially read 9 bits: A,B,Sel,Start,U,D,L,R,then 1
        latch();
        seq9 = 9'b1_0000_1001;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            rd_p1 = 1'b1;
            check_eq($sformatf("t2_read%0d", i + 1), {7'd0, p1_data}, {7'd0, seq9[i]});
            check_eq($sformatf("t2_p2_read%0d", i + 1), {7'd0, p2_data}, 8'h00);
            @(negedge clk);
            rd_p1 = 1'b0;
        end

        // 3. Mask decoding patterns
        keycode = 32'h4F52_0000;
        wait_buttons("t3_p2_up_right", 8'h00, 8'h90);
        keycode = 32'h0E0E_0000;
        wait_buttons("t3_dup_a", 8'h01, 8'h00);
        keycode = 32'h0000_0000;
        wait_buttons("t3_none", 8'h00, 8'h00);

        // 4. Read coinciding with a strobe-high write
        keycode = 32'h0000_0E28;
        wait_buttons("t4_setup", 8'h09, 8'h00);
        latch();
        @(negedge clk);
        rd_p1      = 1'b1;
        reg_we     = 1'b1;
        reg_wdata0 = 1'b1;
        check_eq("t4_same_cycle_read", {7'd0, p1_data}, 8'h01);
        @(negedge clk);
        rd_p1      = 1'b0;
        reg_we     = 1'b0;
        reg_wdata0 = 1'b0;
        check_eq("t4_shifted_to_b", {7'd0, p1_data}, 8'h00);
        @(negedge clk);
        check_eq("t4_reloaded_a", {7'd0, p1_data}, 8'h01);
        // Read while strobe is high keeps returning A
        read_p1("t4_strobe_hi_read", 1'b1);
        check_eq("t4_strobe_hi_no_shift", {7'd0, p1_data}, 8'h01);
        strobe_write(1'b0);

        // 5. Keycode change after latch does not disturb the shift register
        latch();
        read_p1("t5_read1", 1'b1);
        read_p1("t5_read2", 1'b0);
        keycode = 32'h0000_0000;
        wait_buttons("t5_cleared", 8'h00, 8'h00);
        seq6 = 6'b00_0010;
        for (int i = 0; i < 6; i++) begin
            read_p1($sformatf("t5_read%0d", i + 3), seq6[i]);
        end

        // Player 2 reads are independent of player 1 reads
        keycode = 32'h0000_5A59;
        wait_buttons("t5b_p2_ab", 8'h00, 8'h03);
        latch();
        @(negedge clk);
        rd_p1 = 1'b1;
        rd_p2 = 1'b1;
        check_eq("t5b_p2_read1", {7'd0, p2_data}, 8'h01);
        check_eq("t5b_p1_read1", {7'd0, p1_data}, 8'h00);
        @(negedge clk);
        rd_p1 = 1'b0;
        check_eq("t5b_p2_read2", {7'd0, p2_data}, 8'h01);
        @(negedge clk);
        rd_p2 = 1'b0;
        check_eq("t5b_p2_read3", {7'd0, p2_data}, 8'h00);

        // 6. Turbo key
        keycode = 32'h0000_000C;
`ifdef NES_JOYPAD_TURBO_EN
        seen0 = 1'b0;
        seen1 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (p1_buttons[0]) seen1 = 1'b1;
            else seen0 = 1'b1;
        end
        check_eq("t6_turbo_seen_high", {7'd0, seen1}, 8'h01);
        check_eq("t6_turbo_seen_low", {7'd0, seen0}, 8'h01);
        check_eq("t6_turbo_other_bits", {1'b0, p1_buttons[7:1]}, 8'h00);
`else
        seen0 = 1'b0;
        seen1 = 1'b0;
        tick(14);
        check_eq("t6_turbo_unmapped_p1", p1_buttons, 8'h00);
        check_eq("t6_turbo_unmapped_p2", p2_buttons, 8'h00);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
